// File: rtl/lstm_gate_scheduler_pkg.sv
// Shared constants and types for the LSTM gate scheduler: default word format,
// gate and config-select encodings, and the sequencer state enum.
package lstm_pkg;

    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_FRACT_WIDTH = 8;

    localparam logic [1:0] GATE_I = 2'd0;
    localparam logic [1:0] GATE_F = 2'd1;
    localparam logic [1:0] GATE_G = 2'd2;
    localparam logic [1:0] GATE_O = 2'd3;

    localparam logic [1:0] SEL_W0 = 2'd0;
    localparam logic [1:0] SEL_W1 = 2'd1;
    localparam logic [1:0] SEL_B  = 2'd2;

    localparam int NUM_GATES = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_e;

endpackage

// File: rtl/lstm_gate_scheduler_if.sv
// Config, input-pair and gate-bundle signals of the scheduler. The slave side is
// the scheduler itself; the master side is whoever feeds it and consumes results.
interface lstm_gate_scheduler_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  cfg_we;
    logic [3:0]            cfg_addr;
    logic [DATA_WIDTH-1:0] cfg_data;
    logic                  cfg_busy;

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] x_in;
    logic [DATA_WIDTH-1:0] h_in;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] gate_i;
    logic [DATA_WIDTH-1:0] gate_f;
    logic [DATA_WIDTH-1:0] gate_g;
    logic [DATA_WIDTH-1:0] gate_o;

    modport master (
        output cfg_we, cfg_addr, cfg_data, in_valid, x_in, h_in, out_ready,
        input  cfg_busy, in_ready, out_valid, gate_i, gate_f, gate_g, gate_o
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, in_valid, x_in, h_in, out_ready,
        output cfg_busy, in_ready, out_valid, gate_i, gate_f, gate_g, gate_o
    );

endinterface

// File: rtl/lstm_gate_scheduler_gate_mac.sv
// Shared combinational gate datapath: out = (W0*x >>> F) + (W1*h >>> F) + b,
// every term truncated to the word width and summed with wrap-around.
module gate_mac
    import lstm_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int FRACT_WIDTH = DEF_FRACT_WIDTH
) (
    input  logic signed [DATA_WIDTH-1:0] x_i,
    input  logic signed [DATA_WIDTH-1:0] h_i,
    input  logic signed [DATA_WIDTH-1:0] w0_i,
    input  logic signed [DATA_WIDTH-1:0] w1_i,
    input  logic signed [DATA_WIDTH-1:0] b_i,
    output logic signed [DATA_WIDTH-1:0] out_o
);

    // Only the low DATA_WIDTH+FRACT_WIDTH product bits survive the scaling, so the
    // multiply is evaluated at that width; the low bits of a signed product are exact.
    logic signed [DATA_WIDTH+FRACT_WIDTH-1:0] prod0;
    logic signed [DATA_WIDTH+FRACT_WIDTH-1:0] prod1;
    logic signed [DATA_WIDTH-1:0]             term0;
    logic signed [DATA_WIDTH-1:0]             term1;

    assign prod0 = w0_i * x_i;
    assign prod1 = w1_i * h_i;
    assign term0 = DATA_WIDTH'(prod0 >>> FRACT_WIDTH);
    assign term1 = DATA_WIDTH'(prod1 >>> FRACT_WIDTH);
    assign out_o = term0 + term1 + b_i;

endmodule

// File: rtl/lstm_gate_scheduler.sv
// Time-multiplexes one gate_mac across the four LSTM gates of a timestep, one gate
// per cycle, and presents the finished bundle with a valid/ready handshake.
module lstm_gate_scheduler
    import lstm_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int FRACT_WIDTH = DEF_FRACT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lstm_gate_scheduler_if.slave  bus
);

    state_e                state_q;
    logic [1:0]            cnt_q;
    logic [DATA_WIDTH-1:0] x_q;
    logic [DATA_WIDTH-1:0] h_q;
    logic [DATA_WIDTH-1:0] gate_q [NUM_GATES];
    logic                  out_valid_q;
    logic                  in_ready_q;
    logic                  cfg_busy_q;

    logic [DATA_WIDTH-1:0] w0_arr [NUM_GATES];
    logic [DATA_WIDTH-1:0] w1_arr [NUM_GATES];
    logic [DATA_WIDTH-1:0] b_arr  [NUM_GATES];
    logic [DATA_WIDTH-1:0] mac_out;

    logic       cfg_wr;
    logic [1:0] cfg_gate;
    logic [1:0] cfg_sel;

    assign cfg_gate = bus.cfg_addr[3:2];
    assign cfg_sel  = bus.cfg_addr[1:0];
    assign cfg_wr   = bus.cfg_we && (state_q == IDLE);

    // One W0/W1/b triple per gate; reserved selects fall through the case untouched.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_GATES; gi++) begin : g_cfg
            logic [DATA_WIDTH-1:0] w0_q;
            logic [DATA_WIDTH-1:0] w1_q;
            logic [DATA_WIDTH-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    w0_q <= '0;
                    w1_q <= '0;
                    b_q  <= '0;
                end else if (cfg_wr && (cfg_gate == 2'(gi))) begin
                    case (cfg_sel)
                        SEL_W0:  w0_q <= bus.cfg_data;
                        SEL_W1:  w1_q <= bus.cfg_data;
                        SEL_B:   b_q  <= bus.cfg_data;
                        default: ;
                    endcase
                end
            end

            assign w0_arr[gi] = w0_q;
            assign w1_arr[gi] = w1_q;
            assign b_arr[gi]  = b_q;
        end
    endgenerate

    gate_mac #(
        .DATA_WIDTH  (DATA_WIDTH),
        .FRACT_WIDTH (FRACT_WIDTH)
    ) u_gate_mac (
        .x_i   (x_q),
        .h_i   (h_q),
        .w0_i  (w0_arr[cnt_q]),
        .w1_i  (w1_arr[cnt_q]),
        .b_i   (b_arr[cnt_q]),
        .out_o (mac_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            x_q         <= '0;
            h_q         <= '0;
            for (int g = 0; g < NUM_GATES; g++) gate_q[g] <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            cfg_busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        x_q        <= bus.x_in;
                        h_q        <= bus.h_in;
                        cnt_q      <= '0;
                        state_q    <= COMPUTE;
                        in_ready_q <= 1'b0;
                        cfg_busy_q <= 1'b1;
                    end
                end
                COMPUTE: begin
                    gate_q[cnt_q] <= mac_out;
                    cnt_q         <= cnt_q + 2'd1;
                    if (cnt_q == GATE_O) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        cfg_busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.cfg_busy  = cfg_busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.gate_i    = gate_q[GATE_I];
    assign bus.gate_f    = gate_q[GATE_F];
    assign bus.gate_g    = gate_q[GATE_G];
    assign bus.gate_o    = gate_q[GATE_O];

endmodule

// File: tb/tb_lstm_gate_scheduler.sv
// Self-checking bench for lstm_gate_scheduler: directed scenarios plus randomized
// config/transaction traffic checked against a plain-arithmetic gate model.
module tb_lstm_gate_scheduler;

    localparam int DW = 16;
    localparam int FW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    lstm_gate_scheduler_if #(.DATA_WIDTH(DW)) bus ();

    lstm_gate_scheduler #(
        .DATA_WIDTH  (DW),
        .FRACT_WIDTH (FW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference configuration as the bench believes it should be.
    logic [DW-1:0] m_w0 [4];
    logic [DW-1:0] m_w1 [4];
    logic [DW-1:0] m_b  [4];
    bit            m_idle = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] get_gate(input int k);
        case (k)
            0:       return bus.gate_i;
            1:       return bus.gate_f;
            2:       return bus.gate_g;
            default: return bus.gate_o;
        endcase
    endfunction

    // Real-valued view: each product is floored to 1/256 and everything wraps mod 2^16.
    function automatic logic [DW-1:0] ref_gate(input int g, input logic [DW-1:0] x,
                                               input logic [DW-1:0] h);
        longint p0, p1, s;
        p0 = longint'($signed(m_w0[g])) * longint'($signed(x));
        p1 = longint'($signed(m_w1[g])) * longint'($signed(h));
        s  = (p0 >>> FW) + (p1 >>> FW) + longint'($signed(m_b[g]));
        return DW'(s);
    endfunction

    task automatic model_reset();
        for (int g = 0; g < 4; g++) begin
            m_w0[g] = '0;
            m_w1[g] = '0;
            m_b[g]  = '0;
        end
        m_idle = 1'b1;
    endtask

    task automatic model_cfg(input int g, input int s, input logic [DW-1:0] d);
        if (m_idle) begin
            case (s)
                0:       m_w0[g] = d;
                1:       m_w1[g] = d;
                2:       m_b[g]  = d;
                default: ;
            endcase
        end
    endtask

    task automatic cfg_write(input int g, input int s, input logic [DW-1:0] d);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 4'((g << 2) | s);
        bus.cfg_data = d;
        model_cfg(g, s, d);
        @(negedge clk);
        bus.cfg_we = 1'b0;
        $display("cfg  gate=%0d sel=%0d data=0x%04h idle=%0d", g, s, d, m_idle);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    // One full transaction: accept, four gate writes, optional backpressure, handshake.
    task automatic run_txn(input string tag, input logic [DW-1:0] x, input logic [DW-1:0] h,
                           input int hold, input bit same_cfg, input int cg, input int cs,
                           input logic [DW-1:0] cd);
        logic [DW-1:0] exp [4];
        chk({tag, "_in_ready_idle"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.x_in     = x;
        bus.h_in     = h;
        if (same_cfg) begin
            bus.cfg_we   = 1'b1;
            bus.cfg_addr = 4'((cg << 2) | cs);
            bus.cfg_data = cd;
            model_cfg(cg, cs, cd);
        end
        for (int g = 0; g < 4; g++) exp[g] = ref_gate(g, x, h);
        @(negedge clk);
        m_idle       = 1'b0;
        bus.cfg_we   = 1'b0;
        bus.x_in     = DW'($urandom);
        bus.h_in     = DW'($urandom);
        chk({tag, "_in_ready_busy"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "_cfg_busy"}, 32'(bus.cfg_busy), 32'd1);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) bus.in_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("%s_gate%0d", tag, k), 32'(get_gate(k)), 32'(exp[k]));
            chk($sformatf("%s_valid%0d", tag, k), 32'(bus.out_valid), (k == 3) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < hold; i++) begin
            if (i == 0) begin
                bus.cfg_we   = 1'b1;
                bus.cfg_addr = 4'b0000;
                bus.cfg_data = DW'($urandom);
                model_cfg(0, 0, bus.cfg_data);
            end
            @(negedge clk);
            bus.cfg_we = 1'b0;
            chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, "_hold_ready"}, 32'(bus.in_ready), 32'd0);
            chk({tag, "_hold_busy"}, 32'(bus.cfg_busy), 32'd1);
            for (int k = 0; k < 4; k++)
                chk($sformatf("%s_hold_gate%0d", tag, k), 32'(get_gate(k)), 32'(exp[k]));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        m_idle        = 1'b1;
        chk({tag, "_post_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_post_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_post_busy"}, 32'(bus.cfg_busy), 32'd0);
        $display("txn  %s x=0x%04h h=0x%04h -> i=0x%04h f=0x%04h g=0x%04h o=0x%04h",
                 tag, x, h, bus.gate_i, bus.gate_f, bus.gate_g, bus.gate_o);
    endtask

    initial begin
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_data  = '0;
        bus.in_valid  = 1'b0;
        bus.x_in      = '0;
        bus.h_in      = '0;
        bus.out_ready = 1'b0;
        model_reset();

        repeat (3) @(negedge clk);
        chk("rst_valid_low", 32'(bus.out_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_cfg_busy", 32'(bus.cfg_busy), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        for (int k = 0; k < 4; k++) chk($sformatf("rst_gate%0d", k), 32'(get_gate(k)), 32'd0);

        // Basic Q8.8 on gate i
        cfg_write(0, 0, 16'h0100);
        cfg_write(0, 1, 16'h0080);
        cfg_write(0, 2, 16'h0040);
        run_txn("basic", 16'h0200, 16'hFF00, 0, 1'b0, 0, 0, '0);
        chk("basic_gate_i", 32'(bus.gate_i), 32'h01C0);
        chk("basic_gate_f", 32'(bus.gate_f), 32'h0000);

        // Distinct gates from a clean configuration
        do_reset();
        cfg_write(2, 0, 16'h0100);
        cfg_write(3, 2, 16'hFF80);
        cfg_write(1, 3, 16'h1234);
        run_txn("distinct", 16'h0300, 16'h0000, 0, 1'b0, 0, 0, '0);
        chk("distinct_gate_g", 32'(bus.gate_g), 32'h0300);
        chk("distinct_gate_o", 32'(bus.gate_o), 32'hFF80);
        chk("distinct_gate_i", 32'(bus.gate_i), 32'h0000);
        chk("distinct_gate_f", 32'(bus.gate_f), 32'h0000);

        // Wrap-around on gate f
        cfg_write(1, 0, 16'h7FFF);
        run_txn("wrap1", 16'h0200, 16'h0000, 0, 1'b0, 0, 0, '0);
        chk("wrap1_gate_f", 32'(bus.gate_f), 32'hFFFE);
        cfg_write(1, 2, 16'h7FFF);
        cfg_write(1, 1, 16'h0100);
        run_txn("wrap2", 16'h0000, 16'h0100, 0, 1'b0, 0, 0, '0);
        chk("wrap2_gate_f", 32'(bus.gate_f), 32'h80FF);

        // Backpressure with a dropped config write, then confirm the old weight is used
        run_txn("bp", 16'h0100, 16'h0000, 10, 1'b0, 0, 0, '0);
        run_txn("bp_after", 16'h0100, 16'h0000, 0, 1'b0, 0, 0, '0);
        chk("bp_after_gate_i", 32'(bus.gate_i), 32'h0000);

        // Config write on the same edge as the accept
        run_txn("same_edge", 16'h0000, 16'h0000, 0, 1'b1, 0, 2, 16'h0100);
        chk("same_edge_gate_i", 32'(bus.gate_i), 32'h0100);

        // Asynchronous reset after gate_f has been written
        bus.in_valid = 1'b1;
        bus.x_in     = 16'h0400;
        bus.h_in     = 16'h0100;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        for (int k = 0; k < 4; k++) chk($sformatf("arst_gate%0d", k), 32'(get_gate(k)), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
        run_txn("arst_rerun", 16'h0400, 16'h0100, 0, 1'b0, 0, 0, '0);
        chk("arst_rerun_gate_i", 32'(bus.gate_i), 32'h0000);
        chk("arst_rerun_gate_o", 32'(bus.gate_o), 32'h0000);

        // Randomized traffic
        for (int it = 0; it < 30; it++) begin
            int ncfg;
            ncfg = int'($urandom_range(0, 4));
            for (int c = 0; c < ncfg; c++)
                cfg_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), DW'($urandom));
            run_txn($sformatf("rnd%0d", it), DW'($urandom), DW'($urandom),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), DW'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
